// File: rtl/bus_register_bank_if.sv
// Control and monitor signals of the bus register bank.
// The shared tri-state data bus itself stays a plain inout port on the bank.
interface bus_register_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();
  localparam int SELW = $clog2(DEPTH);

  logic                   load;
  logic [SELW-1:0]        load_sel;
  logic                   out_en;
  logic [SELW-1:0]        out_sel;
  logic                   inc;
  logic [SELW-1:0]        inc_sel;
  logic [DEPTH*WIDTH-1:0] regs_flat;
  logic                   inc_wrap;

  modport master (
    output load, load_sel, out_en, out_sel, inc, inc_sel,
    input  regs_flat, inc_wrap
  );

  modport slave (
    input  load, load_sel, out_en, out_sel, inc, inc_sel,
    output regs_flat, inc_wrap
  );
endinterface

// File: rtl/bus_register_bank.sv
// Bank of DEPTH registers on the shared tri-state system bus: load from bus,
// drive bus, or increment in place, with every register also visible on regs_flat.
module bus_register_bank #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  bus_register_bank_if.slave ctrl
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_incWrap;
  logic [WIDTH-1:0] w_loadData;
  logic             w_incEffective;

  assign bus = (ctrl.out_en && rst_n) ? r_regs[ctrl.out_sel] : {WIDTH{1'bz}};

  // A transfer takes the source register directly instead of reading our own drive back off the bus.
  assign w_loadData     = ctrl.out_en ? r_regs[ctrl.out_sel] : bus;
  assign w_incEffective = ctrl.inc && !(ctrl.load && (ctrl.load_sel == ctrl.inc_sel));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= RESET_VALUE;
      end
      r_incWrap <= 1'b0;
    end else begin
      r_incWrap <= 1'b0;
      if (w_incEffective) begin
        r_regs[ctrl.inc_sel] <= r_regs[ctrl.inc_sel] + ONE;
        r_incWrap            <= &r_regs[ctrl.inc_sel];
      end
      // Placed after the increment so a load to the same register wins.
      if (ctrl.load) begin
        r_regs[ctrl.load_sel] <= w_loadData;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign ctrl.regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
  end

  assign ctrl.inc_wrap = r_incWrap;
endmodule

// File: tb/tb_bus_register_bank.sv
// Self-checking bench for bus_register_bank: directed boundary cases, a randomized
// run against a behavioural model, and a WIDTH=4/DEPTH=8 parameter instance.
module tb_bus_register_bank;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  wire  [W-1:0] bus;
  logic         tbBusEn;
  logic [W-1:0] tbBusVal;
  assign bus = tbBusEn ? tbBusVal : {W{1'bz}};

  bus_register_bank_if #(.WIDTH(W), .DEPTH(D)) busIf ();

  bus_register_bank #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .ctrl  (busIf)
  );

  wire [3:0] busSmall;
  bus_register_bank_if #(.WIDTH(4), .DEPTH(8)) smallIf ();

  bus_register_bank #(.WIDTH(4), .DEPTH(8), .RESET_VALUE(4'h5)) dutSmall (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busSmall),
    .ctrl  (smallIf)
  );

  int compareCount = 0;
  int failCount    = 0;

  logic [W-1:0] modelRegs [D];
  logic         modelWrap;

  function automatic logic [31:0] modelFlat();
    logic [31:0] flat;
    for (int i = 0; i < D; i++) flat[i*W +: W] = modelRegs[i];
    return flat;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // With the block expected to float the bus, the bench drives a probe value and reads it back.
  task automatic checkBusReleased(input string tag, input logic [W-1:0] probe);
    tbBusEn  = 1'b1;
    tbBusVal = probe;
    #1;
    checkOutput(tag, bus, probe);
    tbBusEn  = 1'b0;
  endtask

  task automatic applyStimulus(input logic rstLow,
                               input logic ld,  input logic [1:0] lsel,
                               input logic oe,  input logic [1:0] osel,
                               input logic in,  input logic [1:0] isel,
                               input logic drv, input logic [W-1:0] dval);
    logic [W-1:0] busSeen;
    int           oldVal;
    logic         nextWrap;
    rst_n          = !rstLow;
    busIf.load     = ld;
    busIf.load_sel = lsel;
    busIf.out_en   = oe;
    busIf.out_sel  = osel;
    busIf.inc      = in;
    busIf.inc_sel  = isel;
    tbBusEn        = drv;
    tbBusVal       = dval;
    #1;
    if (oe && !rstLow) checkOutput("busOut", bus, modelRegs[osel]);

    busSeen = oe ? modelRegs[osel] : dval;
    if (rstLow) begin
      for (int i = 0; i < D; i++) modelRegs[i] = 8'h00;
      modelWrap = 1'b0;
    end else begin
      nextWrap = 1'b0;
      if (in && !(ld && lsel == isel)) begin
        oldVal          = int'(modelRegs[isel]);
        nextWrap        = (oldVal == 255);
        modelRegs[isel] = W'((oldVal + 1) % 256);
      end
      if (ld) modelRegs[lsel] = busSeen;
      modelWrap = nextWrap;
    end

    @(posedge clk);
    #1;
    checkOutput("regsFlat", busIf.regs_flat, modelFlat());
    checkOutput("incWrap", busIf.inc_wrap, modelWrap);

    rst_n        = 1'b1;
    busIf.load   = 1'b0;
    busIf.out_en = 1'b0;
    busIf.inc    = 1'b0;
    tbBusEn      = 1'b0;
  endtask

  initial begin
    logic [31:0] expSmall;
    logic        ld, oe, in, drv, rl;
    logic [1:0]  lsel, osel, isel;
    logic [W-1:0] dval;

    tbBusEn  = 1'b0;
    tbBusVal = '0;
    smallIf.load = 1'b0; smallIf.load_sel = '0; smallIf.out_en = 1'b0;
    smallIf.out_sel = '0; smallIf.inc = 1'b0; smallIf.inc_sel = '0;

    // Reset with every operation requested.
    rst_n = 1'b0;
    busIf.load = 1'b1; busIf.load_sel = 2'd1; busIf.out_en = 1'b1;
    busIf.out_sel = 2'd2; busIf.inc = 1'b1; busIf.inc_sel = 2'd3;
    for (int i = 0; i < D; i++) modelRegs[i] = 8'h00;
    modelWrap = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("resetRegs", busIf.regs_flat, 32'h0000_0000);
      checkOutput("resetWrap", busIf.inc_wrap, 1'b0);
      checkBusReleased("resetBusZ", 8'h5A);
    end
    rst_n = 1'b1;
    busIf.load = 1'b0; busIf.out_en = 1'b0; busIf.inc = 1'b0;

    // External load of 0xA5 into reg2, then zero-latency readback.
    applyStimulus(0, 1, 2'd2, 0, 2'd0, 0, 2'd0, 1, 8'hA5);
    applyStimulus(0, 0, 2'd0, 1, 2'd2, 0, 2'd0, 0, 8'h00);
    checkBusReleased("busReleased", 8'h00);

    // Register-to-register transfer reg0 -> reg3.
    applyStimulus(0, 1, 2'd0, 0, 2'd0, 0, 2'd0, 1, 8'h3C);
    applyStimulus(0, 1, 2'd3, 0, 2'd0, 0, 2'd0, 1, 8'h00);
    applyStimulus(0, 1, 2'd3, 1, 2'd0, 0, 2'd0, 0, 8'h00);
    checkOutput("xferReg3", busIf.regs_flat[31:24], 8'h3C);
    checkOutput("xferReg0", busIf.regs_flat[7:0], 8'h3C);
    applyStimulus(0, 1, 2'd0, 1, 2'd0, 0, 2'd0, 0, 8'h00);

    // Increment 0xFE twice, then idle to see the wrap pulse drop.
    applyStimulus(0, 1, 2'd1, 0, 2'd0, 0, 2'd0, 1, 8'hFE);
    applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 2'd1, 0, 8'h00);
    checkOutput("incToFF", busIf.regs_flat[15:8], 8'hFF);
    applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 2'd1, 0, 8'h00);
    checkOutput("wrapPulse", busIf.inc_wrap, 1'b1);
    applyStimulus(0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 8'h00);
    checkOutput("wrapDrop", busIf.inc_wrap, 1'b0);

    // Same-register load and increment: load wins, no wrap.
    applyStimulus(0, 1, 2'd1, 0, 2'd0, 0, 2'd0, 1, 8'hFF);
    applyStimulus(0, 1, 2'd1, 0, 2'd0, 1, 2'd1, 1, 8'h10);
    checkOutput("loadWins", busIf.regs_flat[15:8], 8'h10);
    checkOutput("loadWinsNoWrap", busIf.inc_wrap, 1'b0);
    applyStimulus(0, 1, 2'd0, 0, 2'd0, 1, 2'd1, 1, 8'h77);

    // Reset in the middle of a transfer-plus-increment.
    applyStimulus(1, 1, 2'd3, 1, 2'd2, 1, 2'd0, 0, 8'h00);

    for (int n = 0; n < 300; n++) begin
      rl   = ($urandom_range(0, 31) == 0);
      ld   = $urandom_range(0, 1);
      oe   = $urandom_range(0, 1);
      in   = $urandom_range(0, 1);
      lsel = 2'($urandom_range(0, 3));
      osel = 2'($urandom_range(0, 3));
      isel = 2'($urandom_range(0, 3));
      dval = 8'($urandom_range(0, 255));
      drv  = !oe && ld;
      applyStimulus(rl, ld, lsel, oe, osel, in, isel, drv, dval);
    end

    // Parameter sweep: WIDTH=4, DEPTH=8, RESET_VALUE=5.
    expSmall = {8{4'h5}};
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("smallReset", smallIf.regs_flat, expSmall);
    checkOutput("smallResetWrap", smallIf.inc_wrap, 1'b0);
    smallIf.inc = 1'b1;
    smallIf.inc_sel = 3'd7;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("smallReg7F", smallIf.regs_flat[31:28], 4'hF);
    checkOutput("smallNoWrapYet", smallIf.inc_wrap, 1'b0);
    @(posedge clk);
    #1;
    smallIf.inc = 1'b0;
    checkOutput("smallReg7Zero", smallIf.regs_flat[31:28], 4'h0);
    checkOutput("smallWrapPulse", smallIf.inc_wrap, 1'b1);
    smallIf.out_en = 1'b1;
    smallIf.out_sel = 3'd0;
    #1;
    checkOutput("smallBusOut", busSmall, 4'h5);
    @(posedge clk);
    #1;
    smallIf.out_en = 1'b0;
    checkOutput("smallWrapDrop", smallIf.inc_wrap, 1'b0);
    checkOutput("smallOthers", smallIf.regs_flat[27:0], expSmall[27:0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule

// File: doc/bus_register_bank.md
# bus_register_bank

Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, attached to the shared tri-state system bus of the 8-bit computer. This is the next generation of the single-bit tri-state buffer/register cell. Any register can load from the bus, drive the bus through a tri-state output, or increment in place, which also lets it serve as a program counter or memory-address register. All register contents are also exposed on a non-tri-stated monitor port for the ALU and display logic.

## Interface
- WIDTH, 8, bit width of each register and of the bus (≥1)
- DEPTH, 4, number of registers; power of two, ≥2; SELW = log2(DEPTH)
- RESET_VALUE, 0, value loaded into every register on reset
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk
- bus  inout  WIDTH  shared system bus; driven only when outputting, else high-impedance
- load  input  1  capture bus into register load_sel at next rising edge
- load_sel  input  SELW  destination register for load
- out_en  input  1  drive register out_sel onto bus
- out_sel  input  SELW  source register for bus output
- inc  input  1  increment register inc_sel at next rising edge
- inc_sel  input  SELW  register to increment
- regs_flat  output  DEPTH*WIDTH  all registers, reg i at bits [i*WIDTH +: WIDTH]
- inc_wrap  output  1  registered one-cycle pulse: last increment wrapped all-ones to zero

## Operation
- Bus drive (combinational): bus = regs[out_sel] when out_en=1 and rst_n=1; else all bits Z. Z is forced whenever rst_n=0, regardless of out_en.
- Load: at a rising edge with rst_n=1 and load=1, regs[load_sel] ← bus value present before the edge.
  - If out_en=1 in the same cycle, this is a register-to-register transfer in one cycle: regs[load_sel] ← old regs[out_sel].
  - out_sel == load_sel with out_en=1: the register keeps its value.
  - Bus floating (out_en=0, no external driver): the loaded value is whatever the bus resolves to (X in simulation). This is a legal but undefined-value operation, and the bench must not check it.
- Increment: at a rising edge with rst_n=1 and inc=1, regs[inc_sel] ← (regs[inc_sel] + 1) mod 2^WIDTH.
- Simultaneous load and inc:
  - Different registers: both take effect in the same edge.
  - Same register: load wins, increment is discarded, and inc_wrap is not asserted.
- inc_wrap: set to 1 for exactly one cycle after an edge where an increment took effect on a register holding all-ones. Otherwise it is 0 after every edge.
- Non-selected registers hold their value.
- Reset: on a rising edge with rst_n=0, every register ← RESET_VALUE and inc_wrap ← 0. Reset overrides load and inc, and an operation requested in that cycle is lost. Reset mid-transfer leaves no partial update.
- No FSM beyond the register state. Every operation completes in one clock.

## Timing
- Reset values: regs_flat = {DEPTH{RESET_VALUE}}, inc_wrap = 0, bus = Z.
- Bus output latency: 0 cycles (combinational from out_en, out_sel and register state).
- Load and increment latency: 1 cycle; the new value is visible on regs_flat and bus right after the edge.
- regs_flat is a direct register output with no combinational path from inputs.
- inc_wrap is high in the cycle immediately following the wrapping edge only.
- The external bus driver must not drive while out_en=1. The block does not detect contention.

## Test plan
- Reset: hold rst_n=0 for 2 edges with load=1, inc=1, out_en=1 → regs_flat all 0x00, inc_wrap=0, bus=Z throughout; no register changes.
- External load and readback: bench drives bus=0xA5, load=1, load_sel=2, edge; bench releases bus, out_en=1, out_sel=2 → bus=0xA5 with zero latency; out_en=0 → bus=Z.
- Transfer: reg0=0x3C, reg3=0x00; out_en=1, out_sel=0, load=1, load_sel=3, one edge → reg3=0x3C, reg0=0x3C, other registers unchanged.
- Increment and wrap: reg1=0xFE; inc=1, inc_sel=1 for 2 edges → 0xFF with inc_wrap=0, then 0x00 with inc_wrap=1 for exactly one cycle, then 0.
- Simultaneous operations:
  - load_sel=inc_sel=1, bus=0x10 from bench, reg1=0xFF → reg1=0x10, inc_wrap=0.
  - load_sel=0, inc_sel=1 → both registers update on the same edge.
- Parameter sweep: WIDTH=4, DEPTH=8, RESET_VALUE=4'h5 → after reset all eight nibbles =5; increment of reg7 from 0xF gives 0x0 with a one-cycle inc_wrap pulse.
